// File: rtl/priority_n_final_reg.sv
// rtl/priority_n_final_reg.sv - registered one-hot priority check with error counting and fault FSM
module priority_n_final_reg #(
    parameter int N         = 4,
    parameter int CNT_W     = 8,
    parameter int FAULT_LIM = 3,
    localparam int IDX_W    = (N < 2) ? 1 : $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in,
    input  logic [N-1:0]     err_in,
    input  logic             mal,
    input  logic             all_ok,
    input  logic             clr,
    output logic             out_valid,
    output logic             Y,
    output logic [IDX_W-1:0] idx,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    typedef enum logic [1:0] {S_NORMAL, S_SUSPECT, S_FAULT} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_run;
    logic [3:0]         w_run_next;
    logic [3:0]         w_run_inc;
    logic               r_out_valid;
    logic               r_y;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;
    logic               r_err_sticky;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_fault;

    logic               w_multi;
    logic               w_onehot;
    logic               w_e;
    logic               w_fault_next;
    logic [IDX_W-1:0]   w_idx;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign w_multi  = |(in & (in - N'(1)));
    assign w_onehot = (in != '0) & ~w_multi;
    assign w_e      = (in_valid & w_multi) | mal | ((|err_in) & ~all_ok);

    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // A clear together with an error restarts the run at one, as for the event counter.
    always_comb begin
        w_run_inc = (r_state == S_NORMAL || clr) ? 4'd1
                  : ((r_run == 4'hF) ? r_run : r_run + 4'd1);
    end

    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        case (r_state)
            S_NORMAL, S_SUSPECT: begin
                if (w_e) begin
                    w_run_next   = w_run_inc;
                    w_state_next = (w_run_inc >= 4'(FAULT_LIM)) ? S_FAULT : S_SUSPECT;
                end else begin
                    w_run_next   = 4'd0;
                    w_state_next = S_NORMAL;
                end
            end
            S_FAULT: begin
                if (clr && w_e) begin
                    w_run_next   = 4'd1;
                    w_state_next = (4'd1 >= 4'(FAULT_LIM)) ? S_FAULT : S_SUSPECT;
                end else if (clr) begin
                    w_run_next   = 4'd0;
                    w_state_next = S_NORMAL;
                end
            end
            default: begin
                w_run_next   = 4'd0;
                w_state_next = S_NORMAL;
            end
        endcase
    end

    assign w_fault_next = (w_state_next == S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_NORMAL;
            r_run        <= 4'd0;
            r_out_valid  <= 1'b0;
            r_y          <= 1'b0;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_run       <= w_run_next;
            r_fault     <= w_fault_next;
            r_err       <= w_e;
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y   <= w_onehot & ~w_fault_next;
                r_idx <= w_idx;
            end else begin
                r_y   <= r_y & ~w_fault_next;
            end
            if (w_e) begin
                r_err_sticky <= 1'b1;
                r_err_cnt    <= clr ? CNT_W'(1)
                              : ((r_err_cnt == '1) ? r_err_cnt : r_err_cnt + CNT_W'(1));
            end else if (clr) begin
                r_err_sticky <= 1'b0;
                r_err_cnt    <= '0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign Y          = r_y;
    assign idx        = r_idx;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;
    assign fault      = r_fault;

endmodule

// File: tb/tb_priority_n_final_reg.sv
// tb/tb_priority_n_final_reg.sv - scoreboard bench for priority_n_final_reg (N=4, CNT_W=8, FAULT_LIM=3)
module tb_priority_n_final_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in = '0;
    logic [3:0] err_in = '0;
    logic       mal = 1'b0;
    logic       all_ok = 1'b0;
    logic       clr = 1'b0;
    logic       out_valid;
    logic       Y;
    logic [1:0] idx;
    logic       err;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       ov;
        logic       y;
        logic [1:0] idx;
        logic       err;
        logic       st;
        logic [7:0] cnt;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: 0 NORMAL, 1 SUSPECT, 2 FAULT
    int   m_state = 0;
    int   m_run   = 0;
    exp_t m_out   = '0;

    priority_n_final_reg #(.N(4), .CNT_W(8), .FAULT_LIM(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .err_in(err_in),
        .mal(mal), .all_ok(all_ok), .clr(clr), .out_valid(out_valid), .Y(Y),
        .idx(idx), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_step(input logic iv, input logic [3:0] v, input logic [3:0] e,
                              input logic m, input logic ok, input logic c, input logic r);
        int   pc;
        logic ev;
        int   ns;
        int   nr;
        pc = $countones(v);
        ev = (iv && pc >= 2) || m || ((e != 0) && !ok);
        if (r) begin
            m_state = 0;
            m_run   = 0;
            m_out   = '0;
            return;
        end
        ns = m_state;
        nr = m_run;
        if (m_state == 2) begin
            if (c && ev) begin ns = 1; nr = 1; end
            else if (c)  begin ns = 0; nr = 0; end
        end else if (ev) begin
            nr = (m_state == 0 || c) ? 1 : m_run + 1;
            ns = (nr >= 3) ? 2 : 1;
        end else begin
            ns = 0;
            nr = 0;
        end
        m_state   = ns;
        m_run     = nr;
        m_out.fault = (ns == 2);
        m_out.err   = ev;
        m_out.ov    = iv;
        if (iv) begin
            logic found;
            found = 1'b0;
            m_out.y   = (pc == 1) && (ns != 2);
            m_out.idx = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (v[i] && !found) begin
                    m_out.idx = 2'(i);
                    found = 1'b1;
                end
            end
        end else begin
            m_out.y = m_out.y && (ns != 2);
        end
        if (ev) begin
            m_out.st  = 1'b1;
            m_out.cnt = c ? 8'd1 : ((m_out.cnt == 8'hFF) ? 8'hFF : m_out.cnt + 8'd1);
        end else if (c) begin
            m_out.st  = 1'b0;
            m_out.cnt = 8'd0;
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] v, input logic [3:0] e,
                         input logic m, input logic ok, input logic c, input logic r);
        exp_t want;
        rst = r; in_valid = iv; in = v; err_in = e; mal = m; all_ok = ok; clr = c;
        model_step(iv, v, e, m, ok, c, r);
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            check("out_valid",  {31'd0, out_valid},  {31'd0, want.ov});
            check("Y",          {31'd0, Y},          {31'd0, want.y});
            check("idx",        {30'd0, idx},        {30'd0, want.idx});
            check("err",        {31'd0, err},        {31'd0, want.err});
            check("err_sticky", {31'd0, err_sticky}, {31'd0, want.st});
            check("err_cnt",    {24'd0, err_cnt},    {24'd0, want.cnt});
            check("fault",      {31'd0, fault},      {31'd0, want.fault});
        end
    endtask

    initial begin
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        check("rst_cnt", {24'd0, err_cnt}, 32'd0);

        drive(1, 4'b0100, 4'b0000, 0, 0, 0, 0);
        check("r036_y", {31'd0, Y}, 32'd1);
        check("r036_idx", {30'd0, idx}, 32'd2);

        drive(1, 4'b0110, 4'b0000, 0, 0, 0, 0);
        check("r037_idx", {30'd0, idx}, 32'd1);
        check("r037_cnt", {24'd0, err_cnt}, 32'd1);
        drive(1, 4'b1000, 4'b0000, 0, 0, 0, 0);
        check("r037_sticky", {31'd0, err_sticky}, 32'd1);
        check("r037_idx3", {30'd0, idx}, 32'd3);

        drive(0, 4'b0000, 4'b0001, 0, 1, 0, 0);
        check("r038_masked", {31'd0, err}, 32'd0);
        drive(0, 4'b0000, 4'b0001, 0, 0, 0, 0);
        check("r038_err", {31'd0, err}, 32'd1);
        drive(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        check("r038_mal", {31'd0, err}, 32'd1);
        check("r038_ov", {31'd0, out_valid}, 32'd0);

        // Two E cycles above, one more reaches FAULT
        drive(1, 4'b0001, 4'b0000, 1, 0, 0, 0);
        check("r039_fault", {31'd0, fault}, 32'd1);
        check("r039_y_entry", {31'd0, Y}, 32'd0);
        drive(1, 4'b0010, 4'b0000, 0, 0, 0, 0);
        check("r039_y_held", {31'd0, Y}, 32'd0);
        drive(1, 4'b0010, 4'b0000, 0, 0, 1, 0);
        check("r039_clr_fault", {31'd0, fault}, 32'd0);
        check("r039_clr_cnt", {24'd0, err_cnt}, 32'd0);
        check("r039_clr_y", {31'd0, Y}, 32'd1);

        for (int i = 0; i < 300; i++) drive(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        check("r040_sat", {24'd0, err_cnt}, 32'd255);
        drive(0, 4'b0000, 4'b0000, 1, 0, 1, 0);
        check("r040_clr_cnt", {24'd0, err_cnt}, 32'd1);
        check("r040_clr_fault", {31'd0, fault}, 32'd0);
        drive(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        drive(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        check("r040_refault", {31'd0, fault}, 32'd1);

        drive(1, 4'b1111, 4'b1111, 1, 0, 1, 1);
        check("r041_fault", {31'd0, fault}, 32'd0);
        check("r041_cnt", {24'd0, err_cnt}, 32'd0);
        drive(1, 4'b0001, 4'b0000, 0, 0, 0, 0);
        check("r041_y", {31'd0, Y}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), v, 4'($urandom_range(0, 15)) & {4{$urandom_range(0, 5) == 0}},
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
